ram_1w_nr_init: RTL and testbench
=================================

// Module: ram_1w_nr_init
// PURPOSE
//  Parametrised successor of the team's 1-write/1-read RAM: one write port, NUM_RD independent
//  registered read ports, write-to-read forwarding and a hardware init sweep after reset.
//  Used for match/rule state tables in the pattern-matching accelerator, where several lookup
//  lanes read one table while a control path updates it, and the table must be cleared after reset.
// PARAMETERS
//  DWIDTH        36  data word width, bits
//  AWIDTH        9   address width; depth = 2**AWIDTH
//  NUM_RD        2   number of read ports, >= 1
//  INIT_VALUE    0   DWIDTH-bit value written to every word by the init sweep
//  INIT_ON_RESET 1   1: run the init sweep after every reset; 0: skip the sweep, contents undefined
// PORTS
//  clock      in   1              single clock; all logic on its rising edge
//  reset_n    in   1              synchronous reset, active low
//  init_busy  out  1              high while the init sweep runs; ports are ignored while high
//  wr_en      in   1              write request
//  wr_addr    in   AWIDTH         write address
//  wr_data    in   DWIDTH         write data
//  rd_en      in   NUM_RD         per-port read request
//  rd_addr    in   NUM_RD*AWIDTH  port i address in bits [i*AWIDTH +: AWIDTH]
//  rd_valid   out  NUM_RD         per-port read response strobe
//  rd_data    out  NUM_RD*DWIDTH  port i data in bits [i*DWIDTH +: DWIDTH]
// BEHAVIOUR
//  Reset (reset_n low at a clock edge):
//   - rd_valid = 0 and rd_data = 0 for every port.
//   - All in-flight reads and writes are flushed, with no commit and no response.
//   - init_busy = INIT_ON_RESET.
//   - The FSM enters INIT (INIT_ON_RESET=1) or READY (INIT_ON_RESET=0). Sweep counter = 0.
//  FSM states:
//   - INIT: each cycle writes INIT_VALUE to addr = counter, then counter++.
//     After the write to addr 2**AWIDTH-1 the FSM goes to READY and init_busy drops.
//     The sweep takes exactly 2**AWIDTH cycles after reset release.
//   - READY: normal operation; the FSM never leaves READY except through reset.
//   - Reset asserted mid-sweep restarts the sweep at addr 0.
//  While init_busy=1:
//   - wr_en and rd_en are ignored. A request issued then never gets a response or a commit.
//   - rd_valid stays 0.
//  Write path:
//   - A write accepted at edge T (wr_en=1, READY) is visible to all reads accepted at edge T or later.
//  Read path (per port, independent, no back-pressure):
//   - A read accepted at edge T gives rd_valid=1 and rd_data after edge T+2. Latency is fixed at 2.
//   - A port accepts one read per cycle, so throughput is 1 per port per cycle.
//   - rd_valid is high for exactly 1 cycle per accepted read.
//   - rd_data holds its last value when rd_valid=0.
//  Forwarding:
//   - If the read address matches a write accepted at edge T, T-1 or T-2 that is not yet
//     committed to the array, the youngest such write's data is returned.
//   - Write-first semantics: a read and a write to the same address at the same edge
//     returns the new data.
//  Simultaneous reads:
//   - Any number of ports may read the same address in the same cycle; all get identical data.
//  Address arithmetic:
//   - Addresses are unsigned and there is no wrap logic; all 2**AWIDTH words are addressable.
//  Storage is an inferred array with registered address and output; no vendor primitive is used.
// TESTING
//  1. Reset, INIT_ON_RESET=1, AWIDTH=4 -> init_busy high for exactly 16 cycles after release;
//     read all 16 addresses -> every word = INIT_VALUE.
//  2. Write 0xABC to addr 5 at edge T, port0 read addr 5 at edge T -> rd_valid[0] after T+2, data 0xABC.
//  3. Writes 0x1, 0x2 and 0x3 to addr 7 on 3 back-to-back edges, read addr 7 on the third edge
//     -> returns 0x3.
//  4. NUM_RD=4, all ports read addr 3 (holding 0x55) at the same edge, with a write to addr 3
//     one cycle later -> all return 0x55, and a later read returns the new value.
//  5. Assert reset_n low at sweep addr 9, hold 1 cycle, release
//     -> sweep restarts at addr 0 and init_busy lasts 2**AWIDTH cycles again;
//     reads in flight at reset never produce rd_valid.
//  6. rd_en/wr_en pulsed while init_busy=1 -> no rd_valid, and the array holds INIT_VALUE after the sweep.

Source files
------------

// File: rtl/ram_1w_nr_init.sv
// Multi-read-port RAM: one write port, NUM_RD registered read ports (latency 2),
// write-first visibility and a hardware sweep that loads INIT_VALUE after reset.
module ram_1w_nr_init #(
  parameter int              DWIDTH        = 36,
  parameter int              AWIDTH        = 9,
  parameter int              NUM_RD        = 2,
  parameter logic [DWIDTH-1:0] INIT_VALUE  = '0,
  parameter int              INIT_ON_RESET = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  output logic                       init_busy,
  input  logic                       wr_en,
  input  logic [AWIDTH-1:0]          wr_addr,
  input  logic [DWIDTH-1:0]          wr_data,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*AWIDTH-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD*DWIDTH-1:0]   rd_data
);

  localparam int DEPTH = 2 ** AWIDTH;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t            state, state_next;
  logic [AWIDTH-1:0] sweep_cnt, sweep_cnt_next;

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;

  logic [NUM_RD-1:0] s1_valid;
  logic [AWIDTH-1:0] s1_addr [NUM_RD];
  logic [NUM_RD-1:0] s2_valid;
  logic [DWIDTH-1:0] s2_data [NUM_RD];

  // ---------------------------------------------------------------------------
  // Init sweep FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its sources, independent of block order.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state     <= (INIT_ON_RESET != 0) ? ST_INIT : ST_READY;
      sweep_cnt <= '0;
    end else begin
      state     <= state_next;
      sweep_cnt <= sweep_cnt_next;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_next     = state;
    sweep_cnt_next = sweep_cnt;
    case (state)
      ST_INIT: begin
        sweep_cnt_next = sweep_cnt + AWIDTH'(1);
        if (sweep_cnt == {AWIDTH{1'b1}}) state_next = ST_READY;
      end
      default: state_next = ST_READY;
    endcase
  end

  assign init_busy = (state == ST_INIT);

  // ---------------------------------------------------------------------------
  // Storage: the sweep owns the write port while busy, user writes otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_we    = wr_en;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (init_busy) begin
      mem_we    = 1'b1;
      mem_waddr = sweep_cnt;
      mem_wdata = INIT_VALUE;
    end
  end

  // NOTE: the array itself is never reset; clearing is done by the sweep so the
  // storage still maps onto plain block RAM.
  always_ff @(posedge clock) begin
    if (reset_n && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: address register -> array output register -> port output.
  // The array is sampled one edge after acceptance, so a write at the accept
  // edge is already visible (write-first) and later writes are not.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      s1_valid <= '0;
      s2_valid <= '0;
      rd_valid <= '0;
    end else begin
      s1_valid <= rd_en & {NUM_RD{~init_busy}};
      s2_valid <= s1_valid;
      rd_valid <= s2_valid;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RD; i++) begin
      s1_addr[i] <= rd_addr[i*AWIDTH +: AWIDTH];
      if (s1_valid[i]) s2_data[i] <= mem[s1_addr[i]];
    end
  end

  // Output data holds between responses and clears on reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rd_data <= '0;
    end else begin
      for (int i = 0; i < NUM_RD; i++) begin
        if (s2_valid[i]) rd_data[i*DWIDTH +: DWIDTH] <= s2_data[i];
      end
    end
  end

endmodule

// File: tb/tb_ram_1w_nr_init.sv
// Randomised and directed bench for ram_1w_nr_init, checked cycle by cycle
// against an array-plus-response-queue model of the RAM's observable behaviour.
module tb_ram_1w_nr_init;

  localparam int              DW    = 36;
  localparam int              AW    = 4;
  localparam int              NR    = 4;
  localparam int              DEPTH = 16;
  localparam logic [DW-1:0]   IV    = 36'h9_1234_5678;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              init_busy;
  logic              wr_en = 1'b0;
  logic [AW-1:0]     wr_addr = '0;
  logic [DW-1:0]     wr_data = '0;
  logic [NR-1:0]     rd_en = '0;
  logic [NR*AW-1:0]  rd_addr = '0;
  logic [NR-1:0]     rd_valid;
  logic [NR*DW-1:0]  rd_data;

  ram_1w_nr_init #(
    .DWIDTH(DW), .AWIDTH(AW), .NUM_RD(NR), .INIT_VALUE(IV), .INIT_ON_RESET(1)
  ) dut (
    .clock(clock), .reset_n(reset_n), .init_busy(init_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: word contents, remaining sweep cycles, and responses due.
  typedef struct {
    int            due;
    int            port;
    logic [DW-1:0] data;
  } rsp_t;

  logic [DW-1:0] mdl_mem [DEPTH];
  rsp_t          rsp_q [$];
  logic [DW-1:0] last_data [NR];
  int            sweep_left = DEPTH;
  int            cyc = 0;

  task automatic idle();
    wr_en = 1'b0;
    rd_en = '0;
  endtask

  task automatic set_rd(input int p, input int a);
    rd_en[p] = 1'b1;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wr(input int a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
  endtask

  // One clock: update the model with what the DUT sees at the edge, then
  // compare all outputs half a cycle later.
  task automatic step();
    logic [NR-1:0] exp_valid;
    @(posedge clock);
    cyc++;
    if (!reset_n) begin
      sweep_left = DEPTH;
      rsp_q.delete();
      for (int p = 0; p < NR; p++) last_data[p] = '0;
    end else if (sweep_left > 0) begin
      mdl_mem[DEPTH - sweep_left] = IV;
      sweep_left--;
    end else begin
      if (wr_en) mdl_mem[wr_addr] = wr_data;
      for (int p = 0; p < NR; p++)
        if (rd_en[p]) rsp_q.push_back('{cyc + 2, p, mdl_mem[rd_addr[p*AW +: AW]]});
    end
    @(negedge clock);
    exp_valid = '0;
    while (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      exp_valid[rsp_q[0].port] = 1'b1;
      last_data[rsp_q[0].port] = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end
    check("init_busy", 64'(init_busy), 64'(sweep_left > 0));
    check("rd_valid", 64'(rd_valid), 64'(exp_valid));
    for (int p = 0; p < NR; p++)
      check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(last_data[p]));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Count sweep cycles after reset release; bounded so a stuck FSM still ends.
  task automatic expect_sweep(input string tag);
    int n = 0;
    while (init_busy && n < 100) begin
      step();
      n++;
    end
    check(tag, 64'(n), 64'(DEPTH));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) begin
      idle();
      set_rd(a % NR, a);
      step();
    end
    idle();
    steps(3);
  endtask

  initial begin
    // Test 1: reset, sweep length, every word holds INIT_VALUE.
    idle();
    reset_n = 1'b0;
    steps(2);
    check("reset_valid", 64'(rd_valid), 64'(0));
    check("reset_data", 64'(rd_data[DW-1:0]), 64'(0));
    reset_n = 1'b1;
    expect_sweep("sweep_len_1");
    read_all();
    check("init_word5", 64'(last_data[1]), 64'(IV));

    // Test 2: write and read of the same address at the same edge.
    set_wr(5, 36'hABC);
    set_rd(0, 5);
    step();
    idle();
    steps(2);
    check("t2_wr_first", 64'(rd_data[0 +: DW]), 64'h0ABC);

    // Test 3: three back-to-back writes, read on the last one.
    set_wr(7, 36'h1); step();
    set_wr(7, 36'h2); step();
    set_wr(7, 36'h3); set_rd(1, 7); step();
    idle();
    steps(2);
    check("t3_youngest", 64'(rd_data[DW +: DW]), 64'h3);

    // Test 4: all ports read one address, then a write one cycle later.
    set_wr(3, 36'h55); step();
    idle();
    for (int p = 0; p < NR; p++) set_rd(p, 3);
    step();
    idle();
    set_wr(3, 36'hAA); step();
    idle();
    step();
    for (int p = 0; p < NR; p++)
      check($sformatf("t4_same[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'h55);
    set_rd(2, 3); step();
    idle();
    steps(2);
    check("t4_later", 64'(rd_data[2*DW +: DW]), 64'hAA);

    // Test 5a: reads in flight at reset never respond.
    for (int p = 0; p < NR; p++) set_rd(p, p + 8);
    step();
    idle();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    // Test 5b: reset again at sweep address 9, sweep restarts from 0.
    steps(9);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    expect_sweep("sweep_len_restart");

    // Test 6: requests pulsed during the sweep are dropped.
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom);
      wr_data = {4'h0, 32'($urandom)};
      rd_en   = NR'($urandom);
      rd_addr = (NR*AW)'({$urandom, $urandom});
      step();
    end
    idle();
    check("t6_ready", 64'(init_busy), 64'(0));
    read_all();

    // Random traffic with heavy address collisions.
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 99) < 60);
      wr_addr = AW'($urandom);
      wr_data = {4'($urandom), 32'($urandom)};
      rd_en   = NR'($urandom);
      rd_addr = (NR*AW)'({$urandom, $urandom});
      step();
    end
    idle();
    steps(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
